// File: rtl/mac_accum_pkg.sv
// Shared types and default widths for the MAC accumulator slice.
package mac_pkg;

   localparam int DEF_ACT_WIDTH    = 8;
   localparam int DEF_WEIGHT_WIDTH = 8;
   localparam int DEF_ACC_WIDTH    = 32;
   localparam int DEF_LEN_WIDTH    = 16;
   localparam int DEF_OUT_WIDTH    = 8;
   localparam int SHIFT_WIDTH      = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      QUANT = 2'd2,
      DONE  = 2'd3
   } mac_state_t;

endpackage

// File: rtl/mac_accum_if.sv
// Job/stream/result bundle between the activation controller and mac_accum.
interface mac_accum_if
   import mac_pkg::*;
#(
   parameter int ACT_WIDTH    = DEF_ACT_WIDTH,
   parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
   parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
   parameter int LEN_WIDTH    = DEF_LEN_WIDTH,
   parameter int OUT_WIDTH    = DEF_OUT_WIDTH
);

   logic                           START;
   logic [LEN_WIDTH-1:0]           LEN;
   logic signed [ACC_WIDTH-1:0]    BIAS;
   logic [SHIFT_WIDTH-1:0]         SHIFT;
   logic                           RELU_EN;
   logic                           IN_ACT_VALID;
   logic signed [ACT_WIDTH-1:0]    IN_ACT_DATA;
   logic signed [WEIGHT_WIDTH-1:0] WEIGHT_DATA;
   logic                           BUSY;
   logic                           OUT_VALID;
   logic signed [OUT_WIDTH-1:0]    OUT_DATA;
   logic signed [ACC_WIDTH-1:0]    ACC_OUT;
   logic                           OVERFLOW;

   modport master (
      output START, LEN, BIAS, SHIFT, RELU_EN, IN_ACT_VALID, IN_ACT_DATA, WEIGHT_DATA,
      input  BUSY, OUT_VALID, OUT_DATA, ACC_OUT, OVERFLOW
   );

   modport slave (
      input  START, LEN, BIAS, SHIFT, RELU_EN, IN_ACT_VALID, IN_ACT_DATA, WEIGHT_DATA,
      output BUSY, OUT_VALID, OUT_DATA, ACC_OUT, OVERFLOW
   );

endinterface

// File: rtl/mac_accum_requantize.sv
// Rounding arithmetic right shift, optional ReLU, then saturation to OUT_WIDTH.
module requantize
   import mac_pkg::*;
#(
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
   input  logic signed [ACC_WIDTH-1:0] ACC,
   input  logic [SHIFT_WIDTH-1:0]      SHIFT,
   input  logic                        RELU_EN,
   output logic signed [OUT_WIDTH-1:0] RESULT
);

   // Output range limits, sign-extended to the rounding width.
   localparam logic signed [ACC_WIDTH:0] MAX_V =
      {{(ACC_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] MIN_V =
      {{(ACC_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   logic signed [ACC_WIDTH:0] rnd;
   logic signed [ACC_WIDTH:0] wide;
   logic signed [ACC_WIDTH:0] r;

   // One extra bit keeps the half-LSB rounding add from wrapping.
   always_comb begin
      rnd = '0;
      if (SHIFT != '0) begin
         rnd = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 5'd1);
      end
      wide = {ACC[ACC_WIDTH-1], ACC} + rnd;
      r    = wide >>> SHIFT;
      if (RELU_EN && r[ACC_WIDTH]) begin
         r = '0;
      end
      if (r > MAX_V) begin
         RESULT = MAX_V[OUT_WIDTH-1:0];
      end else if (r < MIN_V) begin
         RESULT = MIN_V[OUT_WIDTH-1:0];
      end else begin
         RESULT = r[OUT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mac_accum.sv
// Signed dot-product accumulator with bias, requantization and sticky overflow.
module mac_accum
   import mac_pkg::*;
#(
   parameter int ACT_WIDTH    = DEF_ACT_WIDTH,
   parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
   parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
   parameter int LEN_WIDTH    = DEF_LEN_WIDTH,
   parameter int OUT_WIDTH    = DEF_OUT_WIDTH
) (
   input logic       CLK,
   input logic       RESETN,
   input logic       CLEAR,
   mac_accum_if.slave bus
);

   mac_state_t state, state_nxt;

   logic signed [ACC_WIDTH-1:0]              acc;
   logic [LEN_WIDTH-1:0]                     count;
   logic [LEN_WIDTH-1:0]                     len_q;
   logic [SHIFT_WIDTH-1:0]                   shift_q;
   logic                                     relu_q;
   logic                                     overflow_q;
   logic signed [OUT_WIDTH-1:0]              out_data_q;
   logic signed [ACC_WIDTH-1:0]              acc_out_q;
   logic signed [OUT_WIDTH-1:0]              quant_w;
   logic signed [ACT_WIDTH+WEIGHT_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0]              prod_ext;
   logic signed [ACC_WIDTH-1:0]              sum;
   logic                                     add_ovf;
   logic                                     take;
   logic                                     last_pair;

   // Product, wrapped sum and signed-overflow detect for the incoming pair.
   always_comb begin
      prod      = bus.IN_ACT_DATA * bus.WEIGHT_DATA;
      prod_ext  = ACC_WIDTH'(prod);
      sum       = acc + prod_ext;
      add_ovf   = (acc[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                  (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
      take      = (state == ACC) && bus.IN_ACT_VALID;
      last_pair = take && (count == len_q - LEN_WIDTH'(1));
   end

   // State register.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; CLEAR overrides every transition.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.START) state_nxt = (bus.LEN != '0) ? ACC : QUANT;
         ACC:     if (last_pair) state_nxt = QUANT;
         QUANT:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (CLEAR) begin
         state_nxt = IDLE;
      end
   end

   // Job latch, accumulation and result capture.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         acc        <= '0;
         count      <= '0;
         len_q      <= '0;
         shift_q    <= '0;
         relu_q     <= 1'b0;
         overflow_q <= 1'b0;
         out_data_q <= '0;
         acc_out_q  <= '0;
      end else if (CLEAR) begin
         acc        <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.START) begin
                  acc        <= bus.BIAS;
                  count      <= '0;
                  overflow_q <= 1'b0;
                  len_q      <= bus.LEN;
                  shift_q    <= bus.SHIFT;
                  relu_q     <= bus.RELU_EN;
               end
            end
            ACC: begin
               if (take) begin
                  acc   <= sum;
                  count <= count + LEN_WIDTH'(1);
                  if (add_ovf) begin
                     overflow_q <= 1'b1;
                  end
               end
            end
            QUANT: begin
               out_data_q <= quant_w;
               acc_out_q  <= acc;
            end
            default: ;
         endcase
      end
   end

   requantize #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_requantize (
      .ACC     (acc),
      .SHIFT   (shift_q),
      .RELU_EN (relu_q),
      .RESULT  (quant_w)
   );

   assign bus.BUSY      = (state != IDLE);
   assign bus.OUT_VALID = (state == DONE);
   assign bus.OUT_DATA  = out_data_q;
   assign bus.ACC_OUT   = acc_out_q;
   assign bus.OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum with an arithmetic reference model and scoreboard.
module tb_mac_accum;

   logic CLK = 1'b0;
   logic RESETN;
   logic CLEAR;

   mac_accum_if bus ();

   mac_accum dut (
      .CLK    (CLK),
      .RESETN (RESETN),
      .CLEAR  (CLEAR),
      .bus    (bus)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int     due;
      longint acc;
      longint out;
      longint ovf;
      bit     has_lit;
      longint lit_acc;
      longint lit_out;
   } exp_t;

   exp_t   expq[$];
   longint last_out = 0;
   longint last_acc = 0;

   longint m_acc;
   longint m_ovf;
   int     m_shift;
   bit     m_relu;
   int     pa[$];
   int     pw[$];

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint wrap32(input longint v);
      longint m;
      m = v & 64'h0000_0000_FFFF_FFFF;
      if (m[31]) m = m - 64'h1_0000_0000;
      return m;
   endfunction

   // Reference requantization: floor division by 2^s after half-LSB rounding.
   function automatic longint quant(input longint a, input int s, input bit relu);
      longint r;
      longint one;
      one = 1;
      r = (s > 0) ? ((a + (one <<< (s - 1))) >>> s) : a;
      if (relu && r < 0) r = 0;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      return r;
   endfunction

   task automatic model_add(input int a, input int w);
      longint e;
      e = m_acc + longint'(a) * longint'(w);
      if (e > 64'sd2147483647 || e < -64'sd2147483648) m_ovf = 1;
      m_acc = wrap32(e);
   endtask

   task automatic push_exp(input bit has_lit, input longint lit_acc, input longint lit_out);
      exp_t e;
      e.due     = cyc + 2;
      e.acc     = m_acc;
      e.out     = quant(m_acc, m_shift, m_relu);
      e.ovf     = m_ovf;
      e.has_lit = has_lit;
      e.lit_acc = lit_acc;
      e.lit_out = lit_out;
      expq.push_back(e);
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   // Scoreboard: result strobe only on the scheduled cycle, outputs held otherwise.
   always @(negedge CLK) begin
      exp_t e;
      if (!RESETN) begin
         chk("rst_busy", longint'(bus.BUSY), 0);
         chk("rst_out_valid", longint'(bus.OUT_VALID), 0);
         chk("rst_out_data", longint'(bus.OUT_DATA), 0);
         chk("rst_acc_out", longint'(bus.ACC_OUT), 0);
         chk("rst_overflow", longint'(bus.OVERFLOW), 0);
         expq.delete();
         last_out = 0;
         last_acc = 0;
      end else begin
         if (expq.size() != 0 && expq[0].due < cyc) begin
            chk("out_valid_missed", 0, 1);
            e = expq.pop_front();
         end
         if (expq.size() != 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            chk("out_valid", longint'(bus.OUT_VALID), 1);
            chk("out_data", longint'(bus.OUT_DATA), e.out);
            chk("acc_out", longint'(bus.ACC_OUT), e.acc);
            chk("overflow", longint'(bus.OVERFLOW), e.ovf);
            if (e.has_lit) begin
               chk("lit_acc_out", longint'(bus.ACC_OUT), e.lit_acc);
               chk("lit_out_data", longint'(bus.OUT_DATA), e.lit_out);
            end
            last_out = e.out;
            last_acc = e.acc;
         end else begin
            chk("out_valid_idle", longint'(bus.OUT_VALID), 0);
            chk("out_data_hold", longint'(bus.OUT_DATA), last_out);
            chk("acc_out_hold", longint'(bus.ACC_OUT), last_acc);
         end
      end
   end

   task automatic drive_idle_inputs();
      bus.START        = 1'b0;
      bus.IN_ACT_VALID = 1'b0;
      bus.IN_ACT_DATA  = 8'($urandom);
      bus.WEIGHT_DATA  = 8'($urandom);
   endtask

   // Full job using pa/pw; gaps insert invalid cycles, mid_start pulses an
   // ignored START, trail keeps IN_ACT_VALID high into QUANT.
   task automatic run_job(input int len, input longint bias, input int shift, input bit relu,
                          input bit gaps, input bit mid_start, input bit trail,
                          input bit has_lit, input longint lit_acc, input longint lit_out);
      @(negedge CLK);
      bus.START   = 1'b1;
      bus.LEN     = 16'(len);
      bus.BIAS    = 32'(bias);
      bus.SHIFT   = 5'(shift);
      bus.RELU_EN = relu;
      m_acc   = bias;
      m_ovf   = 0;
      m_shift = shift;
      m_relu  = relu;
      if (len == 0) push_exp(has_lit, lit_acc, lit_out);
      @(negedge CLK);
      chk("busy_after_start", longint'(bus.BUSY), 1);
      drive_idle_inputs();
      bus.LEN     = 16'($urandom);
      bus.BIAS    = 32'($urandom);
      bus.SHIFT   = 5'($urandom);
      bus.RELU_EN = ~relu;
      for (int i = 0; i < len; i++) begin
         if (gaps && (i % 2 == 1)) begin
            drive_idle_inputs();
            @(negedge CLK);
         end
         bus.START        = (mid_start && i == 1);
         bus.IN_ACT_VALID = 1'b1;
         bus.IN_ACT_DATA  = 8'(pa[i]);
         bus.WEIGHT_DATA  = 8'(pw[i]);
         model_add(pa[i], pw[i]);
         if (i == len - 1) push_exp(has_lit, lit_acc, lit_out);
         @(negedge CLK);
      end
      drive_idle_inputs();
      bus.IN_ACT_VALID = trail;
      @(negedge CLK);
      drive_idle_inputs();
      repeat (3) @(negedge CLK);
      chk("busy_after_job", longint'(bus.BUSY), 0);
   endtask

   initial begin
      RESETN = 1'b0;
      CLEAR  = 1'b0;
      drive_idle_inputs();
      bus.LEN     = '0;
      bus.BIAS    = '0;
      bus.SHIFT   = '0;
      bus.RELU_EN = 1'b0;
      repeat (2) @(negedge CLK);
      RESETN = 1'b1;
      chk("reset_busy", longint'(bus.BUSY), 0);

      pa = '{1, 3, -5, 7};
      pw = '{2, 4, 6, -8};
      run_job(4, 0, 0, 0, 0, 0, 0, 1, -72, -72);

      run_job(0, 300, 2, 0, 0, 0, 0, 1, 300, 75);
      run_job(0, -300, 2, 1, 0, 0, 0, 1, -300, 0);

      pa = '{127, 127, 127};
      pw = '{127, 127, 127};
      run_job(3, 0, 0, 0, 0, 0, 1, 1, 48387, 127);
      run_job(3, 0, 10, 0, 0, 0, 0, 1, 48387, 47);

      pa = '{1};
      pw = '{1};
      run_job(1, 64'sh7FFF_FFFF, 0, 0, 0, 0, 0, 1, -64'sd2147483648, -128);
      chk("overflow_sticky_idle", longint'(bus.OVERFLOW), 1);

      pa = '{10, -4, 3, 8};
      pw = '{10, 7, -9, 2};
      run_job(4, -20, 2, 0, 1, 1, 0, 1, 41, 10);

      // Abort: overflow mid-job, gap, ignored START, then CLEAR with START and valid.
      @(negedge CLK);
      bus.START = 1'b1; bus.LEN = 16'd4; bus.BIAS = 32'h7FFF_FFFF;
      bus.SHIFT = 5'd0; bus.RELU_EN = 1'b0;
      @(negedge CLK);
      drive_idle_inputs();
      bus.IN_ACT_VALID = 1'b1; bus.IN_ACT_DATA = 8'sd1; bus.WEIGHT_DATA = 8'sd1;
      @(negedge CLK);
      drive_idle_inputs();
      @(negedge CLK);
      bus.IN_ACT_VALID = 1'b1; bus.IN_ACT_DATA = 8'sd2; bus.WEIGHT_DATA = 8'sd3;
      @(negedge CLK);
      drive_idle_inputs();
      bus.START = 1'b1; bus.LEN = 16'd1;
      @(negedge CLK);
      chk("busy_before_clear", longint'(bus.BUSY), 1);
      chk("overflow_midjob", longint'(bus.OVERFLOW), 1);
      CLEAR = 1'b1;
      bus.START = 1'b1;
      bus.IN_ACT_VALID = 1'b1;
      @(negedge CLK);
      chk("busy_after_clear", longint'(bus.BUSY), 0);
      chk("overflow_after_clear", longint'(bus.OVERFLOW), 0);
      bus.START = 1'b1;
      @(negedge CLK);
      chk("clear_overrides_start", longint'(bus.BUSY), 0);
      CLEAR = 1'b0;
      drive_idle_inputs();
      repeat (4) @(negedge CLK);
      chk("busy_idle_after_clear", longint'(bus.BUSY), 0);

      // Asynchronous reset in the middle of accumulation.
      @(negedge CLK);
      bus.START = 1'b1; bus.LEN = 16'd4; bus.BIAS = 32'd100;
      @(negedge CLK);
      drive_idle_inputs();
      bus.IN_ACT_VALID = 1'b1; bus.IN_ACT_DATA = 8'sd5; bus.WEIGHT_DATA = 8'sd5;
      @(negedge CLK);
      chk("busy_before_reset", longint'(bus.BUSY), 1);
      #2 RESETN = 1'b0;
      #1;
      chk("async_busy", longint'(bus.BUSY), 0);
      chk("async_out_data", longint'(bus.OUT_DATA), 0);
      chk("async_acc_out", longint'(bus.ACC_OUT), 0);
      chk("async_out_valid", longint'(bus.OUT_VALID), 0);
      chk("async_overflow", longint'(bus.OVERFLOW), 0);
      drive_idle_inputs();
      repeat (2) @(negedge CLK);
      RESETN = 1'b1;

      pa = '{-3, 2};
      pw = '{4, -1};
      run_job(2, 5, 1, 0, 0, 0, 0, 1, -9, -4);

      repeat (2) @(negedge CLK);
      chk("no_pending_results", longint'(expq.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_accum.md
MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 SHALL have parameter ACT_WIDTH, default 8: signed activation width.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 8: signed weight width.
REQ-003 SHALL have parameter ACC_WIDTH, default 32: accumulator, bias and ACC_OUT width.
REQ-004 SHALL have parameter LEN_WIDTH, default 16: dot-product length field width.
REQ-005 SHALL have parameter OUT_WIDTH, default 8: requantized output width.
REQ-006 CLK  input  1  sole clock; all logic on rising edge.
REQ-007 RESETN  input  1  asynchronous, active-low reset.
REQ-008 CLEAR  input  1  synchronous abort to IDLE.
REQ-009 START  input  1  job start; latches LEN, BIAS, SHIFT, RELU_EN.
REQ-010 LEN  input  LEN_WIDTH  number of act/weight pairs in the job.
REQ-011 BIAS  input  ACC_WIDTH  signed accumulator initial value.
REQ-012 SHIFT  input  5  requantization right-shift amount.
REQ-013 RELU_EN  input  1  clamp negative results to 0.
REQ-014 IN_ACT_VALID  input  1  IN_ACT_DATA and WEIGHT_DATA valid this cycle.
REQ-015 IN_ACT_DATA  input  ACT_WIDTH  activation byte from upstream input activation controller.
REQ-016 WEIGHT_DATA  input  WEIGHT_WIDTH  weight paired with IN_ACT_DATA.
REQ-017 BUSY  output  1  high in any state other than IDLE.
REQ-018 OUT_VALID  output  1  one-cycle result strobe.
REQ-019 OUT_DATA  output  OUT_WIDTH  requantized signed result.
REQ-020 ACC_OUT  output  ACC_WIDTH  raw accumulator value, held with OUT_DATA.
REQ-021 OVERFLOW  output  1  sticky: accumulator wrapped during the current or last job.

Function
REQ-022 FSM states SHALL be IDLE, ACC, QUANT, DONE.
REQ-023 IDLE: START=1 with LEN!=0 -> ACC; START=1 with LEN=0 -> QUANT; acc loaded with BIAS; OVERFLOW cleared.
REQ-024 ACC: each cycle with IN_ACT_VALID=1 SHALL add sign-extended IN_ACT_DATA * WEIGHT_DATA product to acc and increment element count; cycles with IN_ACT_VALID=0 SHALL hold acc and count.
REQ-025 ACC -> QUANT on the valid cycle where count == LEN-1 (that pair included).
REQ-026 Accumulation SHALL wrap modulo 2^ACC_WIDTH; OVERFLOW SHALL set if a signed-add overflow occurs.
REQ-027 QUANT: if SHIFT>0, r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic, rounding add in ACC_WIDTH+1 bits); if SHIFT=0, r = acc.
REQ-028 QUANT: if RELU_EN and r<0, r=0; r SHALL then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-029 QUANT -> DONE unconditionally; OUT_DATA and ACC_OUT registered at this transition.
REQ-030 DONE: OUT_VALID=1 for exactly one cycle, then -> IDLE; OUT_DATA/ACC_OUT SHALL hold until the next DONE.
REQ-031 Latency: last valid pair at cycle t -> OUT_VALID at t+2; LEN=0 job: START at t -> OUT_VALID at t+2.
REQ-032 START while BUSY=1 SHALL be ignored; IN_ACT_VALID outside ACC SHALL be ignored.
REQ-033 CLEAR SHALL override START and IN_ACT_VALID: next state IDLE, acc/count=0, OVERFLOW=0, no OUT_VALID.
REQ-034 Latched job parameters SHALL not change mid-job regardless of LEN/BIAS/SHIFT/RELU_EN inputs.

Reset
REQ-035 RESETN=0 SHALL asynchronously force IDLE, acc=0, count=0, BUSY=0, OUT_VALID=0, OUT_DATA=0, ACC_OUT=0, OVERFLOW=0.
REQ-036 Reset mid-job SHALL discard the job with no OUT_VALID; release is synchronous to CLK.

Structure
REQ-037 Package mac_pkg SHALL hold the state enum mac_state_t and default width constants.
REQ-038 Combinational sub-module requantize SHALL implement REQ-027/028 (inputs acc, SHIFT, RELU_EN; output OUT_WIDTH).

Verification
REQ-039 BIAS=0, LEN=4, SHIFT=0, pairs (1,2),(3,4),(-5,6),(7,-8) -> ACC_OUT=-72, OUT_DATA=-72 (0xB8), OUT_VALID 2 cycles after 4th pair.
REQ-040 LEN=0, BIAS=300, SHIFT=2 -> OUT_DATA=75, ACC_OUT=300; BIAS=-300, RELU_EN=1 -> OUT_DATA=0.
REQ-041 LEN=3, pairs (127,127) x3, SHIFT=0 -> ACC_OUT=48387, OUT_DATA=127 (saturated); SHIFT=10 -> OUT_DATA=47.
REQ-042 BIAS=0x7FFFFFFF, LEN=1, pair (1,1) -> ACC_OUT=0x80000000, OVERFLOW=1, OUT_DATA=-128.
REQ-043 LEN=4 with IN_ACT_VALID gaps, second START mid-job, then CLEAR after 2 pairs -> second START ignored, CLEAR yields IDLE, no OUT_VALID.
REQ-044 RESETN asserted asynchronously mid-ACC -> all outputs 0 before next edge; fresh job afterwards gives correct result.
